// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between pc_sequencer (master) and the control, hazard and
// imem logic around it (slave).
interface pc_sequencer_if;
  // Handshake: pc advances only on an edge where fetch_valid && imem_ready && !stall.
  // Redirect requests (jr/jump/branch_taken) are levels that the control unit holds
  // until that advance. A redirect seen while stall=1 is captured instead, and the
  // captured target is applied on the first unstalled edge without needing imem_ready.
  logic        stall;
  logic        imem_ready;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  pc_sel;
  logic        fetch_valid;
  logic        redirect_pending;

  modport master (
    input  stall, imem_ready, branch_taken, branch_offset,
           jump, jump_target, jr, jr_addr,
    output pc, pc_plus4, pc_sel, fetch_valid, redirect_pending
  );

  modport slave (
    output stall, imem_ready, branch_taken, branch_offset,
           jump, jump_target, jr, jr_addr,
    input  pc, pc_plus4, pc_sel, fetch_valid, redirect_pending
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter register and next-PC source selection, with a one-entry
// buffer for redirects that arrive while the pipeline is stalled.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    pc_sequencer_if.master    bus,
    output logic [1:0]        fsm_state
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [1:0]  psel_q, psel_d;

    logic [31:0] seq_t, br_t, j_t, jr_t, sel_t;
    logic [1:0]  win_sel;
    logic        redirect;

    always_comb begin
        seq_t    = pc_q + 32'd4;
        br_t     = seq_t + {bus.branch_offset[29:0], 2'b00};
        j_t      = {seq_t[31:28], bus.jump_target, 2'b00};
        jr_t     = {bus.jr_addr[31:2], 2'b00};
        redirect = bus.jr | bus.jump | bus.branch_taken;
        // jr > jump > branch > sequential
        if (bus.jr) begin
            win_sel = 2'd3;
            sel_t   = jr_t;
        end else if (bus.jump) begin
            win_sel = 2'd2;
            sel_t   = j_t;
        end else if (bus.branch_taken) begin
            win_sel = 2'd1;
            sel_t   = br_t;
        end else begin
            win_sel = 2'd0;
            sel_t   = seq_t;
        end
    end

    always_comb begin
        state_d              = state_q;
        pc_d                 = pc_q;
        pend_d               = pend_q;
        psel_d               = psel_q;
        bus.fetch_valid      = 1'b0;
        bus.redirect_pending = 1'b0;
        bus.pc_sel           = 2'd0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                bus.fetch_valid = 1'b1;
                bus.pc_sel      = win_sel;
                if (!bus.stall) begin
                    if (bus.imem_ready) pc_d = sel_t;
                end else if (redirect) begin
                    pend_d  = sel_t;
                    psel_d  = win_sel;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                bus.redirect_pending = 1'b1;
                bus.pc_sel           = psel_q;
                if (bus.stall) begin
                    // Newest redirect replaces the buffered one.
                    if (redirect) begin
                        pend_d = sel_t;
                        psel_d = win_sel;
                    end
                end else begin
                    pc_d    = pend_q;
                    pend_d  = 32'd0;
                    psel_d  = 2'd0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC_ALIGNED;
            pend_q  <= 32'd0;
            psel_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            psel_q  <= psel_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = seq_t;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a cycle-level
// behavioural model of the PC rules.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic [1:0] fsm_state;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  string ctx = "init";

  // reference model state
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_ptgt;
  logic [1:0]  m_psel;
  int          n_mode;
  logic [31:0] n_pc;
  logic [31:0] n_ptgt;
  logic [1:0]  n_psel;

  function automatic logic [1:0] m_win();
    if (bus.jr) return 2'd3;
    if (bus.jump) return 2'd2;
    if (bus.branch_taken) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] m_target(input logic [1:0] s);
    logic [31:0] jt;
    jt = {6'd0, bus.jump_target};
    case (s)
      2'd3:    return bus.jr_addr & 32'hFFFF_FFFC;
      2'd2:    return ((m_pc + 32'd4) & 32'hF000_0000) | (jt * 32'd4);
      2'd1:    return m_pc + 32'd4 + bus.branch_offset * 32'd4;
      default: return m_pc + 32'd4;
    endcase
  endfunction

  task automatic model_next();
    logic redir;
    redir  = bus.jr | bus.jump | bus.branch_taken;
    n_mode = m_mode; n_pc = m_pc; n_ptgt = m_ptgt; n_psel = m_psel;
    if (reset) begin
      n_mode = M_BOOT; n_pc = RESET_PC; n_ptgt = 0; n_psel = 0;
    end else if (m_mode == M_BOOT) begin
      n_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (!bus.stall && bus.imem_ready) n_pc = m_target(m_win());
      else if (bus.stall && redir) begin
        n_ptgt = m_target(m_win()); n_psel = m_win(); n_mode = M_HOLD;
      end
    end else begin
      if (bus.stall) begin
        if (redir) begin n_ptgt = m_target(m_win()); n_psel = m_win(); end
      end else begin
        n_pc = m_ptgt; n_ptgt = 0; n_psel = 0; n_mode = M_RUN;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s/%s: got %h, expected %h", ctx, tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [1:0] exp_sel;
    exp_sel = (m_mode == M_RUN) ? m_win() : (m_mode == M_HOLD) ? m_psel : 2'd0;
    chk("pc", bus.pc, m_pc);
    chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    chk("pc_sel", {30'd0, bus.pc_sel}, {30'd0, exp_sel});
    chk("fetch_valid", {31'd0, bus.fetch_valid}, (m_mode == M_RUN) ? 32'd1 : 32'd0);
    chk("redirect_pending", {31'd0, bus.redirect_pending}, (m_mode == M_HOLD) ? 32'd1 : 32'd0);
    chk("pc_aligned", {30'd0, bus.pc[1:0]}, 32'd0);
  endtask

  // check current outputs, then clock one edge and advance the model
  task automatic step();
    #1;
    check_outputs();
    model_next();
    @(posedge clk);
    #1;
    m_mode = n_mode; m_pc = n_pc; m_ptgt = n_ptgt; m_psel = n_psel;
  endtask

  // driver tasks
  task automatic drive(input logic st, input logic ir, input logic bt, input logic [31:0] bo,
                       input logic j, input logic [25:0] jt, input logic r, input logic [31:0] ra);
    bus.stall = st; bus.imem_ready = ir; bus.branch_taken = bt; bus.branch_offset = bo;
    bus.jump = j; bus.jump_target = jt; bus.jr = r; bus.jr_addr = ra;
  endtask

  task automatic idle(input logic ir);
    drive(1'b0, ir, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
  endtask

  task automatic goto_pc(input logic [31:0] a);
    idle(1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, a);
    step();
  endtask

  task automatic expect_const(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk(tag, got, exp);
  endtask

  initial begin
    reset = 1'b1;
    idle(1'b1);
    m_mode = M_BOOT; m_pc = RESET_PC; m_ptgt = 0; m_psel = 0;
    @(posedge clk);
    #1;

    ctx = "reset";
    step();
    reset = 1'b0;
    idle(1'b1);
    ctx = "boot";
    #1;
    expect_const("boot_fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
    expect_const("boot_pc", bus.pc, 32'h0);
    step();
    ctx = "seq";
    for (int i = 0; i < 4; i++) begin
      expect_const("seq_pc", bus.pc, 32'(i * 4));
      step();
    end

    ctx = "branch_back";
    goto_pc(32'h100);
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0, 1'b0, 32'd0);
    #1;
    expect_const("branch_sel", {30'd0, bus.pc_sel}, 32'd1);
    step();
    expect_const("branch_pc", bus.pc, 32'h0000_00FC);

    ctx = "jr_beats_jump";
    goto_pc(32'h0040_0010);
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 26'h010_0008, 1'b1, 32'h1234_5677);
    #1;
    expect_const("jr_sel", {30'd0, bus.pc_sel}, 32'd3);
    step();
    expect_const("jr_pc", bus.pc, 32'h1234_5674);

    ctx = "stalled_jump";
    goto_pc(32'h20);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 26'h40, 1'b0, 32'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      expect_const("hold_pending", {31'd0, bus.redirect_pending}, 32'd1);
      expect_const("hold_fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
      expect_const("hold_pc", bus.pc, 32'h20);
      step();
    end
    idle(1'b1);
    step();
    expect_const("release_pc", bus.pc, 32'h100);
    expect_const("release_fetch_valid", {31'd0, bus.fetch_valid}, 32'd1);

    ctx = "wrap";
    goto_pc(32'hFFFF_FFFC);
    idle(1'b1);
    step();
    expect_const("wrap_pc", bus.pc, 32'h0);

    ctx = "imem_wait";
    goto_pc(32'h40);
    idle(1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_const("wait_pc", bus.pc, 32'h40);
    end

    ctx = "reset_in_hold";
    goto_pc(32'h80);
    drive(1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 26'd0, 1'b0, 32'd0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(1'b1);
    #1;
    expect_const("rst_pc", bus.pc, RESET_PC);
    expect_const("rst_pending", {31'd0, bus.redirect_pending}, 32'd0);
    expect_const("rst_fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
    step();
    step();
    expect_const("rst_no_apply", bus.pc, RESET_PC + 32'd4);

    ctx = "random";
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0, $urandom,
            $urandom_range(0, 5) == 0, 26'($urandom),
            $urandom_range(0, 7) == 0, $urandom);
      step();
    end
    reset = 1'b0;
    idle(1'b1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program-counter register and decides each cycle which next-PC source the fetch datapath uses: sequential, branch, jump or jump-register. It drives the PC-source select that feeds the PC multiplexer.
- Handshakes with instruction memory (imem_ready) and with the hazard unit (stall).
- A redirect that arrives while the pipeline is stalled is buffered and applied once the stall clears.
- Sits between the control unit / ALU branch compare and the fetch stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit hold; PC must not advance while high
imem_ready  input  1  instruction memory has returned the word at pc this cycle
branch_taken  input  1  conditional branch resolved taken
branch_offset  input  32  sign-extended word offset (imm16 sign-extended)
jump  input  1  J/JAL in flight
jump_target  input  26  instr_index field
jr  input  1  JR in flight
jr_addr  input  32  register-file value for JR
pc  output  32  current fetch address
pc_plus4  output  32  pc + 4, combinational from pc
pc_sel  output  2  source applied at the next advance: 0 seq, 1 branch, 2 jump, 3 jr
fetch_valid  output  1  high when pc is a valid fetch request
redirect_pending  output  1  a buffered redirect is waiting in HOLD

Behaviour:
- Targets:
  - seq = pc+4.
  - branch = pc+4 + (branch_offset<<2).
  - jump = {pc_plus4[31:28], jump_target, 2'b00}.
  - jr = {jr_addr[31:2], 2'b00}.
  - All arithmetic is modulo 2^32, so wrap-around at 32'hFFFF_FFFC goes to 0.
- Priority when several requests are asserted together: jr > jump > branch_taken > seq. pc_sel reflects the winner combinationally.
- FSM states: BOOT, RUN, HOLD.
- Reset (any state, any cycle) puts the block in:
  - state BOOT
  - pc = RESET_PC
  - fetch_valid = 0
  - redirect_pending = 0
  - pending target cleared
  - pc_sel = 0
- BOOT: fetch_valid=0; next cycle go to RUN unconditionally (one idle cycle after reset deasserts).
- RUN: fetch_valid=1.
  - stall=0 and imem_ready=1: pc <= selected target on the next edge (1-cycle latency).
  - stall=0 and imem_ready=0: pc holds; requests on the inputs are ignored (the control unit must hold them until ready).
  - stall=1 with no redirect: pc holds; stay in RUN.
  - stall=1 with any redirect (jr|jump|branch_taken): capture the selected target into the pending register; pc holds; go to HOLD.
- HOLD: fetch_valid=0, redirect_pending=1, pc holds.
  - A new redirect while still stalled overwrites the pending target (newest wins).
  - When stall=0: pc <= pending target (imem_ready is not required); clear pending; go to RUN.
- While pending, pc_sel shows the captured source.
- stall and imem_ready are both don't-care in BOOT.
- Alignment: pc[1:0] is always 0. A non-aligned RESET_PC is a configuration error; the implementation forces the low 2 bits to 0.

Test Plan:
- Reset with RESET_PC=0, then release reset, imem_ready=1, no redirects -> fetch_valid=0 in the first cycle; then pc = 0, 4, 8, 12 on successive cycles; pc_sel=0.
- pc=0x100, branch_taken=1, branch_offset=32'hFFFF_FFFE, imem_ready=1 -> next pc = 0x104 - 8 = 0xFC; pc_sel=1.
- pc=0x0040_0010, jump=1, jump_target=26'h010_0008 and jr=1, jr_addr=0x1234_5677 in the same cycle -> jr wins; pc_sel=3; next pc = 0x1234_5674.
- pc=0x20, stall=1, jump=1 with jump_target=26'h40, then jump=0 for 2 stalled cycles, then stall=0 -> redirect_pending=1 and fetch_valid=0 during HOLD; pc stays 0x20; pc becomes 0x100 the cycle after stall drops; then RUN.
- pc=0xFFFF_FFFC, imem_ready=1 -> next pc = 0x0000_0000 (wrap). Separately, imem_ready=0 for 3 cycles at pc=0x40 -> pc stays 0x40 throughout.
- In HOLD with a pending target, assert reset for 1 cycle -> pc=RESET_PC, redirect_pending=0, state BOOT; the pending target is not applied later.
